// File: rtl/escritura_resultado.sv
// Signed 16-bit product to eight-digit multiplexed seven-segment display.
// A captured value is converted to BCD by sequential double dabble, then
// latched into display registers that the digit scanner reads.
module escritura_resultado #(
  parameter int REFRESCO_LIM = 99999
) (
  input  logic        Clk_100M,
  input  logic        reset,
  input  logic [15:0] producto,
  input  logic        producto_valido,
  output logic        listo,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int CNT_W = (REFRESCO_LIM > 0) ? $clog2(REFRESCO_LIM + 1) : 1;
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(REFRESCO_LIM);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {ESPERA, CONVIERTE, ACTUALIZA} estado_t;

  estado_t            r_estado, w_estado_sig;
  logic        [4:0]  r_cnt;
  logic               r_signo;
  logic        [15:0] r_mag;
  logic        [19:0] r_bcd;
  logic        [19:0] r_disp;
  logic               r_disp_signo;
  logic [CNT_W-1:0]   r_scan;
  logic        [2:0]  r_idx;
  logic signed [15:0] w_prod_s;
  logic        [15:0] w_mag;
  logic        [4:0]  w_shown;

  // One double-dabble correction: every BCD nibble >= 5 gets 3 added.
  function automatic logic [19:0] f_dabble(input logic [19:0] bcd);
    logic [19:0] r;
    r = bcd;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Magnitude of the signed input; 0x8000 maps to 32768 as an unsigned value.
  assign w_prod_s = producto;
  assign w_mag    = w_prod_s[15] ? $unsigned(-w_prod_s) : $unsigned(w_prod_s);

  assign listo = (r_estado == ESPERA);
  assign DP    = 1'b1;
  assign AN    = ~(8'h01 << r_idx);

  // Next-state logic: strobes outside ESPERA are simply dropped.
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      ESPERA:    if (producto_valido) w_estado_sig = CONVIERTE;
      CONVIERTE: if (r_cnt == 5'd1) w_estado_sig = ACTUALIZA;
      ACTUALIZA: w_estado_sig = ESPERA;
      default:   w_estado_sig = ESPERA;
    endcase
  end

  // FSM state, step counter and captured sign.
  always_ff @(posedge Clk_100M or posedge reset) begin
    if (reset) begin
      r_estado <= ESPERA;
      r_cnt    <= 5'd0;
      r_signo  <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      if (r_estado == ESPERA && producto_valido) begin
        r_cnt   <= 5'd16;
        r_signo <= producto[15];
      end else if (r_estado == CONVIERTE) begin
        r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  // Conversion datapath: load magnitude, then one correct-and-shift per cycle.
  always_ff @(posedge Clk_100M) begin
    if (r_estado == ESPERA && producto_valido) begin
      r_mag <= w_mag;
      r_bcd <= 20'd0;
    end else if (r_estado == CONVIERTE) begin
      {r_bcd, r_mag} <= {f_dabble(r_bcd), r_mag} << 1;
    end
  end

  // Display registers only move in ACTUALIZA, so the shown value never glitches.
  always_ff @(posedge Clk_100M or posedge reset) begin
    if (reset) begin
      r_disp       <= 20'd0;
      r_disp_signo <= 1'b0;
    end else if (r_estado == ACTUALIZA) begin
      r_disp       <= r_bcd;
      r_disp_signo <= r_signo;
    end
  end

  // Refresh divider and digit index; index advances when the divider wraps.
  always_ff @(posedge Clk_100M or posedge reset) begin
    if (reset) begin
      r_scan <= '0;
      r_idx  <= 3'd0;
    end else if (r_scan == LIM_C) begin
      r_scan <= '0;
      r_idx  <= r_idx + 3'd1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  // Segment decode with leading-zero blanking; units digit is always lit.
  always_comb begin
    w_shown[0] = 1'b1;
    w_shown[1] = |r_disp[19:4];
    w_shown[2] = |r_disp[19:8];
    w_shown[3] = |r_disp[19:12];
    w_shown[4] = |r_disp[19:16];
    SEG = SEG_BLANK;
    case (r_idx)
      3'd0: SEG = f_seg7(r_disp[3:0]);
      3'd1: if (w_shown[1]) SEG = f_seg7(r_disp[7:4]);
      3'd2: if (w_shown[2]) SEG = f_seg7(r_disp[11:8]);
      3'd3: if (w_shown[3]) SEG = f_seg7(r_disp[15:12]);
      3'd4: if (w_shown[4]) SEG = f_seg7(r_disp[19:16]);
      3'd5: if (r_disp_signo) SEG = SEG_MINUS;
      default: SEG = SEG_BLANK;
    endcase
  end

endmodule
